fifo_uart_tx: RTL and testbench

Serial transmit stage directly downstream of the 32-deep byte FIFO. It drains the FIFO through its rd/empty/data_out interface and serializes each byte onto a UART-style line: start bit, 8 data bits LSB first, optional parity, then 1 or 2 stop bits. It is the sole reader of the FIFO and accounts for the FIFO's one-cycle registered read latency.

---
 rtl/fifo_uart_pkg.sv | 22 ++
 rtl/uart_bit_timer.sv | 30 +++
 rtl/fifo_uart_tx.sv | 121 ++++++++++++
 tb/tb_fifo_uart_tx.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_uart_pkg.sv
// Shared state encoding, parity selection constants and parity helper for the UART path.
package fifo_uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    LOAD,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  function automatic logic parity_bit(input logic [7:0] d, input int mode);
    return (^d) ^ (mode == PARITY_ODD);
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter: bit_end is high in the last cycle of every CLKS_PER_BIT-long bit.
// Reloads on load or at each bit boundary, so consecutive bits tile with no gaps.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clock,
  input  logic rst,
  input  logic load,
  input  logic run,
  output logic bit_end
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT * 2);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  assign bit_end = run && (cnt == '0);

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load || bit_end) begin
      cnt <= RELOAD;
    end else if (run) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains the byte FIFO one byte at a time and serializes it as start, 8 data (LSB first),
// optional parity and 1-2 stop bits; tx falls 3 cycles after IDLE sees data, no prefetch.
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_MODE  = PARITY_NONE,
  parameter int STOP_BITS    = 1
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              enable,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_rd,
  output logic              tx,
  output logic              busy,
  output logic              frame_done
);

  tx_state_t         state;
  logic [DATA_W-1:0] shreg;
  logic [2:0]        bit_idx;
  logic              par;
  logic              bit_end;
  logic              timer_load;
  logic              timer_run;

  assign timer_load = (state == LOAD);
  assign timer_run  = (state == START) || (state == DATA) ||
                      (state == PARITY) || (state == STOP);

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clock  (clock),
    .rst    (rst),
    .load   (timer_load),
    .run    (timer_run),
    .bit_end(bit_end)
  );

  assign busy       = (state != IDLE);
  assign frame_done = (state == STOP) && bit_end && (bit_idx == 3'(STOP_BITS - 1));

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      tx      <= 1'b1;
      fifo_rd <= 1'b0;
      shreg   <= '0;
      bit_idx <= '0;
      par     <= 1'b0;
    end else begin
      fifo_rd <= 1'b0;
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (enable && !fifo_empty) begin
            state   <= REQ;
            fifo_rd <= 1'b1;
          end
        end
        REQ: state <= LOAD;
        LOAD: begin
          // fifo_data is valid only now, one cycle after the read strobe
          shreg   <= fifo_data;
          par     <= parity_bit(fifo_data, PARITY_MODE);
          bit_idx <= '0;
          tx      <= 1'b0;
          state   <= START;
        end
        START: begin
          if (bit_end) begin
            tx    <= shreg[0];
            state <= DATA;
          end
        end
        DATA: begin
          if (bit_end) begin
            shreg   <= shreg >> 1;
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'(DATA_W - 1)) begin
              // bit_idx wraps to 0 here and is reused to count stop bits
              if (PARITY_MODE != PARITY_NONE) begin
                tx    <= par;
                state <= PARITY;
              end else begin
                tx    <= 1'b1;
                state <= STOP;
              end
            end else begin
              tx <= shreg[1];
            end
          end
        end
        PARITY: begin
          if (bit_end) begin
            tx    <= 1'b1;
            state <= STOP;
          end
        end
        STOP: begin
          if (bit_end) begin
            if (bit_idx == 3'(STOP_BITS - 1)) begin
              state <= IDLE;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end
        end
        default: begin
          tx    <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Three DUT configurations fed by queue-backed FIFO models, checked every cycle against a frame-timeline model.
`timescale 1ns/1ps
module tb_fifo_uart_tx;

  localparam int CPB = 4;
  localparam int PM [3] = '{0, 1, 2};
  localparam int SB [3] = '{1, 1, 2};

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] en = 3'b000;
  logic [2:0] empty = 3'b111;
  logic [2:0] rd, tx, busy, done;
  logic [7:0] data [3] = '{8'h00, 8'h00, 8'h00};
  logic [7:0] q [3][$];

  int         k [3] = '{-1, -1, -1};
  logic [7:0] mb [3] = '{8'h00, 8'h00, 8'h00};
  int         rd_cnt [3] = '{0, 0, 0};
  int         done_cnt [3] = '{0, 0, 0};
  int         n_checks = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  fifo_uart_tx #(.DATA_W(8), .CLKS_PER_BIT(CPB), .PARITY_MODE(0), .STOP_BITS(1)) u0 (
    .clock(clk), .rst(rst), .enable(en[0]), .fifo_empty(empty[0]), .fifo_data(data[0]),
    .fifo_rd(rd[0]), .tx(tx[0]), .busy(busy[0]), .frame_done(done[0]));
  fifo_uart_tx #(.DATA_W(8), .CLKS_PER_BIT(CPB), .PARITY_MODE(1), .STOP_BITS(1)) u1 (
    .clock(clk), .rst(rst), .enable(en[1]), .fifo_empty(empty[1]), .fifo_data(data[1]),
    .fifo_rd(rd[1]), .tx(tx[1]), .busy(busy[1]), .frame_done(done[1]));
  fifo_uart_tx #(.DATA_W(8), .CLKS_PER_BIT(CPB), .PARITY_MODE(2), .STOP_BITS(2)) u2 (
    .clock(clk), .rst(rst), .enable(en[2]), .fifo_empty(empty[2]), .fifo_data(data[2]),
    .fifo_rd(rd[2]), .tx(tx[2]), .busy(busy[2]), .frame_done(done[2]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int flen(input int i);
    return (9 + ((PM[i] != 0) ? 1 : 0) + SB[i]) * CPB;
  endfunction

  // Expected line level j cycles after the start bit began.
  function automatic logic exp_tx(input int i, input logic [7:0] d, input int j);
    int b;
    b = j / CPB;
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    if (b == 9 && PM[i] != 0) return (($countones(d) % 2) == 1) ^ (PM[i] == 2);
    return 1'b1;
  endfunction

  // FIFO model: one-cycle registered read, empty flag refreshed on every edge.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rd[i]) begin
        check($sformatf("u%0d_rd_nonempty", i), 32'(q[i].size() > 0), 32'd1);
        if (q[i].size() > 0) data[i] <= q[i].pop_front();
      end
      empty[i] <= (q[i].size() == 0);
    end
  end

  // k = cycles since IDLE accepted a byte: 1 read strobe, 2 load, 3.. frame bits.
  always @(posedge clk or negedge rst) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst) k[i] = -1;
      else if (k[i] < 0) begin
        if (en[i] && !empty[i]) begin
          k[i]  = 1;
          mb[i] = q[i][0];
        end
      end else if (k[i] == 2 + flen(i)) k[i] = -1;
      else k[i] = k[i] + 1;
    end
  end

  always @(negedge clk) begin
    logic [3:0] e;
    for (int i = 0; i < 3; i++) begin
      if (k[i] < 0) e = 4'b1000;
      else if (k[i] == 1) e = 4'b1110;
      else if (k[i] == 2) e = 4'b1010;
      else e = {exp_tx(i, mb[i], k[i] - 3), 1'b0, 1'b1, (k[i] == 2 + flen(i))};
      check($sformatf("u%0d_cycle_tx_rd_busy_done", i),
            32'({tx[i], rd[i], busy[i], done[i]}), 32'(e));
      if (rd[i]) rd_cnt[i]++;
      if (done[i]) done_cnt[i]++;
    end
  end

  task automatic push(input int i, input logic [7:0] b);
    q[i].push_back(b);
  endtask

  task automatic wait_tx_low(input int i, output int t);
    t = 0;
    while (tx[i] !== 1'b0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t >= 300) check($sformatf("u%0d_tx_start_timeout", i), 32'(tx[i]), 32'd0);
  endtask

  task automatic wait_done(input int i);
    int t;
    t = 0;
    while (done[i] !== 1'b1 && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t >= 300) check($sformatf("u%0d_done_timeout", i), 32'(done[i]), 32'd1);
  endtask

  // Samples each bit mid-period; len counts cycles from start bit to frame_done inclusive.
  task automatic capture(input int i, input int nbits, output logic [15:0] bits,
                         output int len, output int t);
    bits = '0;
    len  = 0;
    wait_tx_low(i, t);
    for (int c = 0; c < 80; c++) begin
      if ((c % CPB) == 1 && (c / CPB) < nbits) bits[c / CPB] = tx[i];
      len = c + 1;
      if (done[i]) break;
      @(negedge clk);
    end
  endtask

  initial begin
    logic [15:0] bits;
    logic [7:0]  seq [3];
    int          len, t, r0;

    // Reset held with work pending: nothing may be read or driven
    push(0, 8'hA5);
    en[0] = 1'b1;
    repeat (6) @(negedge clk);
    check("reset_no_read", 32'(q[0].size()), 32'd1);
    check("reset_outputs", 32'({tx[0], rd[0], busy[0], done[0]}), 32'b1000);
    rst = 1'b1;

    // 0xA5, no parity, one stop bit
    capture(0, 10, bits, len, t);
    check("a5_latency", 32'(t), 32'd3);
    check("a5_bits", 32'(bits[9:0]), 32'h34A);
    check("a5_len", 32'(len), 32'd40);
    check("a5_rd_cnt", 32'(rd_cnt[0]), 32'd1);

    // Parity and two stop bits
    en[1] = 1'b1;
    push(1, 8'h07);
    capture(1, 11, bits, len, t);
    check("even_par_data", 32'(bits[8:1]), 32'h07);
    check("even_par_bit", 32'(bits[9]), 32'd1);
    check("even_par_len", 32'(len), 32'd44);
    en[2] = 1'b1;
    push(2, 8'h07);
    capture(2, 12, bits, len, t);
    check("odd_par_bit", 32'(bits[9]), 32'd0);
    check("two_stop_bits", 32'(bits[11:10]), 32'd3);
    check("odd_2stop_len", 32'(len), 32'd48);

    // Back-to-back bytes
    seq = '{8'h01, 8'h80, 8'hFF};
    r0 = rd_cnt[0];
    for (int n = 0; n < 3; n++) push(0, seq[n]);
    for (int n = 0; n < 3; n++) begin
      capture(0, 10, bits, len, t);
      check($sformatf("b2b%0d_frame", n), 32'(bits[9:0]), 32'({1'b1, seq[n], 1'b0}));
      check($sformatf("b2b%0d_len", n), 32'(len), 32'd40);
      if (n > 0) check($sformatf("b2b%0d_gap", n), 32'(t), 32'd4);
    end
    repeat (20) @(negedge clk);
    check("b2b_rd_cnt", 32'(rd_cnt[0] - r0), 32'd3);
    check("b2b_drained", 32'(q[0].size()), 32'd0);
    check("b2b_idle", 32'(busy[0]), 32'd0);

    // Enable dropped during data bit 3
    r0 = rd_cnt[0];
    push(0, 8'h3C);
    push(0, 8'h55);
    wait_tx_low(0, t);
    repeat (17) @(negedge clk);
    en[0] = 1'b0;
    wait_done(0);
    check("drop_rd_cnt", 32'(rd_cnt[0] - r0), 32'd1);
    check("drop_queue", 32'(q[0].size()), 32'd1);
    repeat (10) @(negedge clk);
    check("drop_no_fetch", 32'(rd_cnt[0] - r0), 32'd1);
    check("drop_idle", 32'(busy[0]), 32'd0);
    en[0] = 1'b1;
    capture(0, 10, bits, len, t);
    check("resume_latency", 32'(t), 32'd3);
    check("resume_frame", 32'(bits[9:0]), 32'h2AA);
    check("resume_len", 32'(len), 32'd40);

    // Reset mid-frame
    r0 = rd_cnt[0];
    push(0, 8'hF0);
    push(0, 8'h0F);
    wait_tx_low(0, t);
    repeat (10) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("rst_async_tx", 32'(tx[0]), 32'd1);
    check("rst_async_busy", 32'(busy[0]), 32'd0);
    check("rst_async_rd", 32'(rd[0]), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    capture(0, 10, bits, len, t);
    check("post_rst_latency", 32'(t), 32'd3);
    check("post_rst_frame", 32'(bits[9:0]), 32'h21E);
    check("post_rst_len", 32'(len), 32'd40);
    check("post_rst_rd_cnt", 32'(rd_cnt[0] - r0), 32'd2);

    repeat (20) @(negedge clk);
    check("u0_frames", 32'(done_cnt[0]), 32'd7);
    check("u0_reads", 32'(rd_cnt[0]), 32'd8);
    check("u1_frames", 32'(done_cnt[1]), 32'd1);
    check("u2_frames", 32'(done_cnt[2]), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
